mcu_bus_receiver: RTL

- Front end of the MCU parallel bus, directly upstream of the psram controller.
- Synchronises the MCU strobe into sysclk and decodes command/data bytes into an address-set and write-stream protocol.
- Buffers the resulting (address, byte) write requests in a small FIFO and presents them to the psram write port via a valid/ready handshake.

---
 rtl/mcu_bus_receiver.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mcu_bus_receiver.sv
// MCU parallel-bus front end: strobe synchroniser, command/data decoder and a
// write-request FIFO with a registered head that feeds the psram write port.
module mcu_bus_receiver #(
   parameter int ADDR_BITS   = 23,
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 sysclk,
   input  logic                 sys_reset_n,
   input  logic                 mcu_bus_clock,
   input  logic [7:0]           mcu_bus,
   input  logic                 mcu_bus_command_data,
   output logic                 wr_valid,
   input  logic                 wr_ready,
   output logic [ADDR_BITS-1:0] wr_address,
   output logic [7:0]           wr_data,
   output logic                 overflow,
   output logic                 busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int EW    = ADDR_BITS + 8;
   localparam logic [CNT_W-1:0]     CNT_FULL   = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_BITS-1:0] LOW16_MASK = ADDR_BITS'(20'h0FFFF);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR_HI,
      ST_ADDR_MID,
      ST_ADDR_LO,
      ST_STREAM
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   pulse_q, pulse_d;
   state_t                 state_q, state_d;
   logic [ADDR_BITS-1:0]   shadow_q, shadow_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic                   overflow_q, overflow_d;
   logic [EW-1:0]          mem_q [FIFO_DEPTH];
   logic [EW-1:0]          mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       mem_cnt_q, mem_cnt_d;
   logic                   out_valid_q, out_valid_d;
   logic [ADDR_BITS-1:0]   out_addr_q, out_addr_d;
   logic [7:0]             out_data_q, out_data_d;

   logic                   push_req, push, pop, load, full;
   logic [CNT_W-1:0]       total;

   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], mcu_bus_clock};
      prev_d     = sync_q[SYNC_STAGES-1];
      pulse_d    = sync_q[SYNC_STAGES-1] & ~prev_q;
      state_d    = state_q;
      shadow_d   = shadow_q;
      addr_d     = addr_q;
      overflow_d = overflow_q;
      push_req   = 1'b0;

      // Bus byte and command flag are held stable by the MCU across the pulse cycle.
      if (pulse_q) begin
         if (mcu_bus_command_data) begin
            case (mcu_bus)
               8'h10:   state_d = ST_ADDR_HI;
               8'h20:   state_d = ST_STREAM;
               8'h30: begin
                  overflow_d = 1'b0;
                  state_d    = ST_IDLE;
               end
               default: state_d = ST_IDLE;
            endcase
         end else begin
            case (state_q)
               ST_ADDR_HI: begin
                  shadow_d = (shadow_q & LOW16_MASK) | (ADDR_BITS'(mcu_bus) << 16);
                  state_d  = ST_ADDR_MID;
               end
               ST_ADDR_MID: begin
                  shadow_d[15:8] = mcu_bus;
                  state_d        = ST_ADDR_LO;
               end
               ST_ADDR_LO: begin
                  addr_d  = {shadow_q[ADDR_BITS-1:8], mcu_bus};
                  state_d = ST_IDLE;
               end
               ST_STREAM: begin
                  push_req = 1'b1;
                  addr_d   = addr_q + ADDR_BITS'(1);
               end
               default: ;
            endcase
         end
      end

      // Valid/ready: a transfer happens on every edge where wr_valid && wr_ready;
      // the head stays stable while wr_valid is high and wr_ready is low.
      total = mem_cnt_q + CNT_W'(out_valid_q);
      full  = (total == CNT_FULL);
      pop   = out_valid_q & wr_ready;
      push  = push_req & (~full | pop);
      load  = (mem_cnt_q != '0) & (~out_valid_q | pop);

      if (push_req && !push) begin
         overflow_d = 1'b1;
      end

      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;

      if (push) begin
         mem_d[wr_ptr_q] = {addr_q, mcu_bus};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (load) begin
         {out_addr_d, out_data_d} = mem_q[rd_ptr_q];
         out_valid_d              = 1'b1;
         rd_ptr_d                 = rd_ptr_q + PTR_W'(1);
      end else if (pop) begin
         out_valid_d = 1'b0;
      end
      mem_cnt_d = mem_cnt_q + CNT_W'(push) - CNT_W'(load);
   end

   always_ff @(posedge sysclk) begin
      if (!sys_reset_n) begin
         sync_q      <= '0;
         prev_q      <= 1'b0;
         pulse_q     <= 1'b0;
         state_q     <= ST_IDLE;
         shadow_q    <= '0;
         addr_q      <= '0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
      end else begin
         sync_q      <= sync_d;
         prev_q      <= prev_d;
         pulse_q     <= pulse_d;
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         addr_q      <= addr_d;
         overflow_q  <= overflow_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_cnt_q   <= mem_cnt_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
      end
   end

   assign wr_valid   = out_valid_q;
   assign wr_address = out_addr_q;
   assign wr_data    = out_data_q;
   assign overflow   = overflow_q;
   assign busy       = (mem_cnt_q != '0) | out_valid_q | (state_q != ST_IDLE);

endmodule
